// File: rtl/ex_hazard_ctrl.sv
// Execute-stage hazard controller: load-use stalls, taken-branch flushes and
// pipeline-enable generation, with saturating stall/flush event counters.
module ex_hazard_ctrl #(
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             control,
    input  logic             ex_load,
    input  logic             ex_jump,
    input  logic             ex_cond,
    input  logic [3:0]       ex_dest,
    input  logic [3:0]       id_rs,
    input  logic [3:0]       id_rt,
    input  logic             id_rs_used,
    input  logic             id_rt_used,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             busy,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    typedef enum logic [1:0] {RUN, STALL, FLUSH} state_t;

    localparam logic [2:0]       REM_INIT = 3'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t     state, state_nxt;
    logic [2:0] rem, rem_nxt;
    logic       hazard, taken;
    logic       stall_inc, flush_inc;

    // Register 0 is hardwired, so a load targeting it never creates a dependency.
    assign hazard = control & ex_load & (ex_dest != 4'd0) &
                    ((id_rs_used & (id_rs == ex_dest)) | (id_rt_used & (id_rt == ex_dest)));
    assign taken  = control & ex_jump & ex_cond;
    assign busy   = (state != RUN);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= RUN;
            rem   <= 3'd0;
        end else begin
            state <= state_nxt;
            rem   <= rem_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        rem_nxt   = rem;
        if (control) begin
            case (state)
                RUN: begin
                    if (taken) begin
                        state_nxt = FLUSH;
                    end else if (hazard && (LOAD_LAT > 1)) begin
                        state_nxt = STALL;
                        rem_nxt   = REM_INIT;
                    end
                end
                STALL: begin
                    rem_nxt = rem - 3'd1;
                    if (rem == 3'd1) state_nxt = RUN;
                end
                FLUSH:   state_nxt = RUN;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Reset forces a safe bubble regardless of inputs; freeze drops every enable.
    always_comb begin
        pc_write    = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        stall_inc   = 1'b0;
        flush_inc   = 1'b0;
        if (!rst_n) begin
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
        end else if (control) begin
            case (state)
                RUN: begin
                    if (taken) begin
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        flush_inc   = 1'b1;
                    end else if (hazard) begin
                        idex_bubble = 1'b1;
                        stall_inc   = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
                STALL: begin
                    idex_bubble = 1'b1;
                    stall_inc   = 1'b1;
                end
                FLUSH: begin
                    pc_write    = 1'b1;
                    ifid_write  = 1'b1;
                    ifid_flush  = 1'b1;
                    idex_bubble = 1'b1;
                end
                default: begin
                    idex_bubble = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_ONE;
            if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_ONE;
        end
    end

endmodule

// File: tb/tb_ex_hazard_ctrl.sv
// Directed bench for ex_hazard_ctrl: one instance with LOAD_LAT=1/16-bit counters
// and one with LOAD_LAT=3/3-bit counters, driven with identical stimulus.
module tb_ex_hazard_ctrl;

    logic clk, rst_n, control, ex_load, ex_jump, ex_cond;
    logic [3:0] ex_dest, id_rs, id_rt;
    logic id_rs_used, id_rt_used;

    logic pc_write1, ifid_write1, ifid_flush1, idex_bubble1, busy1;
    logic [15:0] stall_cnt1, flush_cnt1;
    logic pc_write3, ifid_write3, ifid_flush3, idex_bubble3, busy3;
    logic [2:0] stall_cnt3, flush_cnt3;

    logic [3:0] en1, en3;
    assign en1 = {pc_write1, ifid_write1, ifid_flush1, idex_bubble1};
    assign en3 = {pc_write3, ifid_write3, ifid_flush3, idex_bubble3};

    int n_checks = 0;
    int n_pass   = 0;

    ex_hazard_ctrl #(.LOAD_LAT(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .control(control), .ex_load(ex_load),
        .ex_jump(ex_jump), .ex_cond(ex_cond), .ex_dest(ex_dest), .id_rs(id_rs),
        .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .pc_write(pc_write1), .ifid_write(ifid_write1), .ifid_flush(ifid_flush1),
        .idex_bubble(idex_bubble1), .busy(busy1),
        .stall_cnt(stall_cnt1), .flush_cnt(flush_cnt1)
    );

    ex_hazard_ctrl #(.LOAD_LAT(3), .CNT_W(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .control(control), .ex_load(ex_load),
        .ex_jump(ex_jump), .ex_cond(ex_cond), .ex_dest(ex_dest), .id_rs(id_rs),
        .id_rt(id_rt), .id_rs_used(id_rs_used), .id_rt_used(id_rt_used),
        .pc_write(pc_write3), .ifid_write(ifid_write3), .ifid_flush(ifid_flush3),
        .idex_bubble(idex_bubble3), .busy(busy3),
        .stall_cnt(stall_cnt3), .flush_cnt(flush_cnt3)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
    endtask

    task automatic applyStimulus(input logic ctl, input logic ld, input logic jmp, input logic cond,
                                 input logic [3:0] dest, input logic [3:0] rs, input logic [3:0] rt,
                                 input logic rsu, input logic rtu);
        control    = ctl;
        ex_load    = ld;
        ex_jump    = jmp;
        ex_cond    = cond;
        ex_dest    = dest;
        id_rs      = rs;
        id_rt      = rt;
        id_rs_used = rsu;
        id_rt_used = rtu;
        #1;
    endtask

    task automatic idle();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
    endtask

    task automatic loadUse();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic takenJump();
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0);
    endtask

    task automatic nextCycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        @(negedge clk);

        // Reset overrides even a taken jump.
        applyStimulus(1'b1, 1'b1, 1'b1, 1'b1, 4'd5, 4'd5, 4'd0, 1'b1, 1'b0);
        checkOutput("rst_en1", 32'(en1), 32'h3);
        checkOutput("rst_en3", 32'(en3), 32'h3);
        nextCycle();
        nextCycle();
        rst_n = 1'b1;
        idle();
        checkOutput("rst_busy3", 32'(busy3), 32'h0);
        checkOutput("rst_stall1", 32'(stall_cnt1), 32'h0);
        checkOutput("rst_flush3", 32'(flush_cnt3), 32'h0);
        checkOutput("run_en1", 32'(en1), 32'hC);

        // Load-use dependency.
        loadUse();
        checkOutput("lu_en1", 32'(en1), 32'h1);
        checkOutput("lu_en3", 32'(en3), 32'h1);
        nextCycle();
        idle();
        checkOutput("lu_next_en1", 32'(en1), 32'hC);
        checkOutput("lu_busy1", 32'(busy1), 32'h0);
        checkOutput("lu_stall1", 32'(stall_cnt1), 32'h1);
        checkOutput("lu_st1_en3", 32'(en3), 32'h1);
        checkOutput("lu_st1_busy3", 32'(busy3), 32'h1);
        nextCycle();
        idle();
        checkOutput("lu_st2_en3", 32'(en3), 32'h1);
        checkOutput("lu_st2_busy3", 32'(busy3), 32'h1);
        checkOutput("lu_busy1_b", 32'(busy1), 32'h0);
        nextCycle();
        idle();
        checkOutput("lu_done_en3", 32'(en3), 32'hC);
        checkOutput("lu_done_busy3", 32'(busy3), 32'h0);
        checkOutput("lu_stall3", 32'(stall_cnt3), 32'h3);

        // Taken jump wins over a simultaneous hazard.
        takenJump();
        checkOutput("tj_en1", 32'(en1), 32'hF);
        checkOutput("tj_en3", 32'(en3), 32'hF);
        nextCycle();
        idle();
        checkOutput("fl_en1", 32'(en1), 32'hF);
        checkOutput("fl_busy3", 32'(busy3), 32'h1);
        nextCycle();
        idle();
        checkOutput("fl_done_en3", 32'(en3), 32'hC);
        checkOutput("fl_flush1", 32'(flush_cnt1), 32'h1);
        checkOutput("fl_flush3", 32'(flush_cnt3), 32'h1);
        checkOutput("fl_stall1", 32'(stall_cnt1), 32'h1);
        checkOutput("fl_stall3", 32'(stall_cnt3), 32'h3);

        // Cases that must not stall.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b1, 1'b0);
        checkOutput("nh_r0_en1", 32'(en1), 32'hC);
        nextCycle();
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd7, 4'd7, 4'd2, 1'b0, 1'b1);
        checkOutput("nh_unused_en3", 32'(en3), 32'hC);
        nextCycle();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd3, 4'd3, 4'd0, 1'b1, 1'b0);
        checkOutput("nh_nottaken_en1", 32'(en1), 32'hC);
        nextCycle();
        idle();
        checkOutput("nh_stall1", 32'(stall_cnt1), 32'h1);
        checkOutput("nh_flush3", 32'(flush_cnt3), 32'h1);

        // rt-path hazard, then freeze in the middle of the stall.
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd9, 4'd1, 4'd9, 1'b1, 1'b1);
        checkOutput("rt_en1", 32'(en1), 32'h1);
        checkOutput("rt_en3", 32'(en3), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("frz_en1", 32'(en1), 32'h0);
        checkOutput("frz_en3", 32'(en3), 32'h0);
        checkOutput("frz_busy3", 32'(busy3), 32'h1);
        nextCycle();
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 4'd0, 1'b0, 1'b0);
        checkOutput("frz2_stall3", 32'(stall_cnt3), 32'h4);
        checkOutput("frz2_flush1", 32'(flush_cnt1), 32'h1);
        nextCycle();
        idle();
        checkOutput("thaw1_en3", 32'(en3), 32'h1);
        checkOutput("thaw1_stall3", 32'(stall_cnt3), 32'h4);
        nextCycle();
        idle();
        checkOutput("thaw2_en3", 32'(en3), 32'h1);
        checkOutput("thaw2_stall3", 32'(stall_cnt3), 32'h5);
        nextCycle();
        idle();
        checkOutput("thaw_done_en3", 32'(en3), 32'hC);
        checkOutput("thaw_stall3", 32'(stall_cnt3), 32'h6);
        checkOutput("thaw_stall1", 32'(stall_cnt1), 32'h2);

        // Reset in the middle of a stall.
        loadUse();
        nextCycle();
        idle();
        checkOutput("ra_busy3", 32'(busy3), 32'h1);
        rst_n = 1'b0;
        #1;
        checkOutput("ra_rst_en3", 32'(en3), 32'h3);
        nextCycle();
        rst_n = 1'b1;
        idle();
        checkOutput("ra_busy3_after", 32'(busy3), 32'h0);
        checkOutput("ra_en3_after", 32'(en3), 32'hC);
        checkOutput("ra_stall3_after", 32'(stall_cnt3), 32'h0);
        checkOutput("ra_stall1_after", 32'(stall_cnt1), 32'h0);
        nextCycle();
        idle();
        checkOutput("ra_busy3_later", 32'(busy3), 32'h0);

        // Reset in the middle of a flush.
        takenJump();
        nextCycle();
        idle();
        checkOutput("rf_busy1", 32'(busy1), 32'h1);
        rst_n = 1'b0;
        #1;
        nextCycle();
        rst_n = 1'b1;
        idle();
        checkOutput("rf_busy1_after", 32'(busy1), 32'h0);
        checkOutput("rf_en1_after", 32'(en1), 32'hC);
        checkOutput("rf_flush1_after", 32'(flush_cnt1), 32'h0);

        // Saturation of the narrow counters.
        for (int i = 0; i < 10; i++) begin
            loadUse();
            nextCycle();
        end
        idle();
        nextCycle();
        nextCycle();
        nextCycle();
        idle();
        checkOutput("sat_stall3", 32'(stall_cnt3), 32'h7);
        checkOutput("sat_stall1", 32'(stall_cnt1), 32'd10);
        checkOutput("sat_busy3", 32'(busy3), 32'h0);
        for (int i = 0; i < 8; i++) begin
            takenJump();
            nextCycle();
            idle();
            nextCycle();
        end
        idle();
        checkOutput("sat_flush3", 32'(flush_cnt3), 32'h7);
        checkOutput("sat_flush1", 32'(flush_cnt1), 32'd8);
        checkOutput("sat_stall3_hold", 32'(stall_cnt3), 32'h7);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
